// File: rtl/prog_loader_pkg.sv
// ----------------------------------------------------------------------------
// prog_loader_pkg
// Shared types and constants for the UART program loader.
//
//   loaderState_e  : state encoding used by the loader FSM (uart_prog_loader)
//                    and, for its IDLE/START/DATA/STOP subset, by the byte
//                    receiver (uart_rx_byte).
//   UART_DATA_BITS : data bits per 8N1 character.
//   WORD_BYTES     : bytes packed into one instruction-memory word.
//   WORD_BITS      : width of one instruction-memory word.
//   insertByte()   : drops a byte into one little-endian lane of a word.
// ----------------------------------------------------------------------------
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      START,
      DATA,
      STOP,
      COMMIT,
      FLUSH,
      DONE
   } loaderState_e;

   localparam int UART_DATA_BITS = 8;
   localparam int WORD_BYTES     = 4;
   localparam int WORD_BITS      = WORD_BYTES * UART_DATA_BITS;

   // Lane 0 is the least significant byte, so the first byte received in a
   // word ends up in bits [7:0] (little-endian packing).
   function automatic logic [WORD_BITS-1:0] insertByte(
      input logic [WORD_BITS-1:0]      word,
      input logic [1:0]                lane,
      input logic [UART_DATA_BITS-1:0] dataByte
   );
      logic [WORD_BITS-1:0] result;
      result = word;
      result[{lane, 3'b000} +: UART_DATA_BITS] = dataByte;
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver with a 2-FF input synchronizer and mid-bit sampling.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable_i     in   receiver may start a new character only while high;
//                     dropping it aborts any character in progress
//   rx_i         in   raw asynchronous serial input, idle high
//   busy_o       out  a character (or a suspected start bit) is in progress
//   byte_valid_o out  one-cycle strobe in the cycle the good stop bit is
//                     sampled; byte_data_o is valid alongside it
//   frame_err_o  out  one-cycle strobe in the cycle a low stop bit is sampled
//   byte_data_o  out  received byte, LSB first on the wire
// ----------------------------------------------------------------------------
module uart_rx_byte
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable_i,
   input  logic                      rx_i,
   output logic                      busy_o,
   output logic                      byte_valid_o,
   output logic                      frame_err_o,
   output logic [UART_DATA_BITS-1:0] byte_data_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

   logic                      rxMeta_q;
   logic                      rxSync_q;
   loaderState_e              state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                bitIdx_q, bitIdx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;

   // Two-flop synchronizer for the raw rx pin. Both flops reset to the idle
   // (high) level so that coming out of reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
      end
   end

   // State register plus the bit-period counter, bit index and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
      end
   end

   // Next-state logic. A falling edge moves us into START, where we wait half
   // a bit and re-check the line: a line that has gone high again was a
   // glitch, not a start bit. From there every sample lands in the middle of
   // a bit cell, one full bit period apart. The valid/error strobes are
   // combinational so the loader sees them in the very cycle of the stop
   // sample and can react on the same clock edge.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      bitIdx_d     = bitIdx_q;
      shift_d      = shift_q;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            bitIdx_d = '0;
            if (enable_i && !rxSync_q) begin
               state_d = START;
            end
         end

         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rxSync_q ? IDLE : DATA;
            end
         end

         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d    = '0;
               shift_d  = {rxSync_q, shift_q[UART_DATA_BITS-1:1]};
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end
         end

         STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rxSync_q) begin
                  byte_valid_o = 1'b1;
               end else begin
                  frame_err_o = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (!enable_i) begin
         state_d      = IDLE;
         byte_valid_o = 1'b0;
         frame_err_o  = 1'b0;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign byte_data_o = shift_q;

endmodule

// File: rtl/uart_prog_loader.sv
// ----------------------------------------------------------------------------
// uart_prog_loader
// Loads a program image received over UART into instruction memory. A rising
// edge on start_pg opens a session: the CPU is held in reset (pg_busy), bytes
// are packed little-endian into 32-bit words and written from word address 0
// upwards. A long quiet period on rx closes the session, flushes any partial
// word (upper bytes zero) and pulses pg_done.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start_pg   in   programming request, raw asynchronous board input
//   rx         in   UART serial input, raw asynchronous, idle high
//   pg_busy    out  high for the whole session; CPU held in reset meanwhile
//   imem_we    out  one-cycle instruction-memory write strobe
//   imem_addr  out  word address of the write (held when imem_we is low)
//   imem_wdata out  write data (held when imem_we is low)
//   pg_done    out  one-cycle pulse when the session ends
//   frame_err  out  sticky: a character had a low stop bit
//   ovf        out  sticky: a word was dropped because memory was full
// ----------------------------------------------------------------------------
module uart_prog_loader
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int IDLE_BITS    = 1000,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_pg,
   input  logic                  rx,
   output logic                  pg_busy,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  pg_done,
   output logic                  frame_err,
   output logic                  ovf
);

   localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
   localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
   localparam logic [1:0]        LAST_LANE = 2'(WORD_BYTES - 1);

   logic startMeta_q;
   logic startSync_q;
   logic startPrev_q;
   logic startRise;

   logic                      rxBusy;
   logic                      rxByteValid;
   logic                      rxFrameErr;
   logic [UART_DATA_BITS-1:0] rxByte;
   logic                      rxEnable;

   loaderState_e          state_q, state_d;
   logic [IDLE_W-1:0]     idleCnt_q, idleCnt_d;
   logic [WORD_BITS-1:0]  wordBuf_q, wordBuf_d;
   logic [1:0]            byteIdx_q, byteIdx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  exhausted_q, exhausted_d;
   logic                  pgBusy_q, pgBusy_d;
   logic                  pgDone_q, pgDone_d;
   logic                  frameErr_q, frameErr_d;
   logic                  ovf_q, ovf_d;
   logic                  imemWe_q, imemWe_d;
   logic [ADDR_WIDTH-1:0] imemAddr_q, imemAddr_d;
   logic [WORD_BITS-1:0]  imemWdata_q, imemWdata_d;
   logic                  writeWord;

   // Synchronize start_pg and keep the previous synchronized value for edge
   // detection. Everything resets high, so a button already held down when
   // reset is released is not mistaken for a fresh request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         startMeta_q <= 1'b1;
         startSync_q <= 1'b1;
         startPrev_q <= 1'b1;
      end else begin
         startMeta_q <= start_pg;
         startSync_q <= startMeta_q;
         startPrev_q <= startSync_q;
      end
   end

   assign startRise = startSync_q & ~startPrev_q;

   // The receiver listens only while a session is open, so line noise
   // between sessions never produces bytes.
   assign rxEnable = (state_q == WAIT_START) || (state_q == START) ||
                     (state_q == COMMIT);

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) uRx (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_i     (rxEnable),
      .rx_i         (rx),
      .busy_o       (rxBusy),
      .byte_valid_o (rxByteValid),
      .frame_err_o  (rxFrameErr),
      .byte_data_o  (rxByte)
   );

   // All loader state lives here. Reset drops every output to 0 at once, so
   // a word that was being assembled is simply lost and never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idleCnt_q   <= '0;
         wordBuf_q   <= '0;
         byteIdx_q   <= '0;
         addr_q      <= '0;
         exhausted_q <= 1'b0;
         pgBusy_q    <= 1'b0;
         pgDone_q    <= 1'b0;
         frameErr_q  <= 1'b0;
         ovf_q       <= 1'b0;
         imemWe_q    <= 1'b0;
         imemAddr_q  <= '0;
         imemWdata_q <= '0;
      end else begin
         state_q     <= state_d;
         idleCnt_q   <= idleCnt_d;
         wordBuf_q   <= wordBuf_d;
         byteIdx_q   <= byteIdx_d;
         addr_q      <= addr_d;
         exhausted_q <= exhausted_d;
         pgBusy_q    <= pgBusy_d;
         pgDone_q    <= pgDone_d;
         frameErr_q  <= frameErr_d;
         ovf_q       <= ovf_d;
         imemWe_q    <= imemWe_d;
         imemAddr_q  <= imemAddr_d;
         imemWdata_q <= imemWdata_d;
      end
   end

   // Session control. While the receiver is working on a character the FSM
   // sits in START; the stop-bit strobe either packs the byte (and moves to
   // COMMIT on the fourth one) or flags a framing error and drops it. The
   // idle counter only runs in WAIT_START and restarts whenever the line
   // shows activity, so the timeout measures genuine silence.
   always_comb begin
      state_d     = state_q;
      idleCnt_d   = idleCnt_q;
      wordBuf_d   = wordBuf_q;
      byteIdx_d   = byteIdx_q;
      addr_d      = addr_q;
      exhausted_d = exhausted_q;
      pgBusy_d    = pgBusy_q;
      pgDone_d    = 1'b0;
      frameErr_d  = frameErr_q;
      ovf_d       = ovf_q;
      imemWe_d    = 1'b0;
      imemAddr_d  = imemAddr_q;
      imemWdata_d = imemWdata_q;
      writeWord   = 1'b0;

      case (state_q)
         IDLE: begin
            if (startRise) begin
               state_d     = WAIT_START;
               pgBusy_d    = 1'b1;
               frameErr_d  = 1'b0;
               ovf_d       = 1'b0;
               addr_d      = '0;
               exhausted_d = 1'b0;
               byteIdx_d   = '0;
               wordBuf_d   = '0;
               idleCnt_d   = '0;
            end
         end

         WAIT_START: begin
            if (rxBusy) begin
               state_d   = START;
               idleCnt_d = '0;
            end else if (idleCnt_q == IDLE_LAST) begin
               state_d = FLUSH;
            end else begin
               idleCnt_d = idleCnt_q + 1'b1;
            end
         end

         START, DATA, STOP: begin
            idleCnt_d = '0;
            if (rxByteValid) begin
               wordBuf_d = insertByte(wordBuf_q, byteIdx_q, rxByte);
               byteIdx_d = byteIdx_q + 2'd1;
               state_d   = (byteIdx_q == LAST_LANE) ? COMMIT : WAIT_START;
            end else if (rxFrameErr) begin
               frameErr_d = 1'b1;
               state_d    = WAIT_START;
            end else if (!rxBusy) begin
               state_d = WAIT_START;
            end
         end

         COMMIT: begin
            writeWord = 1'b1;
            idleCnt_d = '0;
            state_d   = WAIT_START;
         end

         FLUSH: begin
            writeWord = (byteIdx_q != 2'd0);
            pgDone_d  = 1'b1;
            state_d   = DONE;
         end

         DONE: begin
            pgBusy_d = 1'b0;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Shared by COMMIT and FLUSH. Once the top address has been written the
      // exhausted flag blocks further writes instead of letting the address
      // wrap back over the start of the program.
      if (writeWord) begin
         if (!exhausted_q) begin
            imemWe_d    = 1'b1;
            imemAddr_d  = addr_q;
            imemWdata_d = wordBuf_q;
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
               exhausted_d = 1'b1;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end else begin
            ovf_d = 1'b1;
         end
         wordBuf_d = '0;
         byteIdx_d = '0;
      end
   end

   assign pg_busy    = pgBusy_q;
   assign pg_done    = pgDone_q;
   assign frame_err  = frameErr_q;
   assign ovf        = ovf_q;
   assign imem_we    = imemWe_q;
   assign imem_addr  = imemAddr_q;
   assign imem_wdata = imemWdata_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_prog_loader
// Directed self-checking bench for uart_prog_loader with a fast bit rate
// (16 clocks per bit, 20-bit idle timeout, 16-word memory).
// ----------------------------------------------------------------------------
module tb_uart_prog_loader;

   localparam int CPB  = 16;
   localparam int IDLE = 20;
   localparam int AW   = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_pg;
   logic          rx;
   logic          pg_busy;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          pg_done;
   logic          frame_err;
   logic          ovf;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [AW-1:0] wrAddr[$];
   logic [31:0]   wrData[$];
   int            wrCycle[$];
   int            weLong    = 0;
   int            doneCount = 0;
   int            doneCycle = 0;
   int            busySeen  = 0;
   logic          prevWe    = 1'b0;

   uart_prog_loader #(
      .CLKS_PER_BIT (CPB),
      .IDLE_BITS    (IDLE),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_pg   (start_pg),
      .rx         (rx),
      .pg_busy    (pg_busy),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .pg_done    (pg_done),
      .frame_err  (frame_err),
      .ovf        (ovf)
   );

   // 10 ns clock and a free-running cycle counter for latency measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cycle = cycle + 1;

   // Passive monitor on the falling edge: logs every write beat, counts
   // write strobes wider than one cycle, pg_done pulses and busy cycles.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wrAddr.push_back(imem_addr);
         wrData.push_back(imem_wdata);
         wrCycle.push_back(cycle);
         if (prevWe === 1'b1) weLong = weLong + 1;
      end
      prevWe = imem_we;
      if (pg_done === 1'b1) begin
         doneCount = doneCount + 1;
         doneCycle = cycle;
      end
      if (pg_busy === 1'b1) busySeen = busySeen + 1;
   end

   // Hard stop in case something wedges the directed sequence.
   initial begin
      repeat (150000) @(posedge clk);
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) else begin
         errors = errors + 1;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Sends one 8N1 character, LSB first, with a selectable stop-bit level.
   task automatic applyStimulus(input logic [7:0] dataByte, input logic stopBit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = dataByte[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stopBit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic clearLog();
      wrAddr.delete();
      wrData.delete();
      wrCycle.delete();
      weLong = 0;
   endtask

   task automatic startSession();
      start_pg = 1'b0;
      repeat (4) @(negedge clk);
      start_pg = 1'b1;
      repeat (4) @(negedge clk);
      start_pg = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Waits (bounded) for the next pg_done pulse and reports how many pulses
   // were seen shortly afterwards; exactly one is expected.
   task automatic waitDone(input string tag, input int budget);
      int startCount;
      int n;
      startCount = doneCount;
      n = 0;
      while (doneCount == startCount && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      checkOutput(tag, 32'(doneCount - startCount), 32'd1);
   endtask

   function automatic logic [31:0] wrAddrAt(input int i);
      if (i < wrAddr.size()) return 32'(wrAddr[i]);
      return 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] wrDataAt(input int i);
      if (i < wrData.size()) return wrData[i];
      return 32'hxxxx_xxxx;
   endfunction

   function automatic int wrCycleAt(input int i);
      if (i < wrCycle.size()) return wrCycle[i];
      return -100000;
   endfunction

   initial begin
      int t4;
      int t8;
      int tEnd;
      int lat;
      logic [31:0] expWord;

      // Reset with start_pg held high: everything 0, no session afterwards.
      rst_n    = 1'b0;
      start_pg = 1'b1;
      rx       = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("rst_pg_busy", 32'(pg_busy), 32'd0);
      checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
      checkOutput("rst_pg_done", 32'(pg_done), 32'd0);
      checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
      checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
      rst_n = 1'b1;
      clearLog();
      busySeen = 0;
      repeat (2000) @(negedge clk);
      checkOutput("held_start_busy_cycles", 32'(busySeen), 32'd0);
      checkOutput("held_start_writes", 32'(wrAddr.size()), 32'd0);

      // Two full words; strobe latency and timeout delay measured in cycles.
      clearLog();
      startSession();
      checkOutput("s1_pg_busy", 32'(pg_busy), 32'd1);
      applyStimulus(8'h78, 1'b1);
      applyStimulus(8'h56, 1'b1);
      applyStimulus(8'h34, 1'b1);
      t4 = cycle;
      applyStimulus(8'h12, 1'b1);
      applyStimulus(8'hEF, 1'b1);
      applyStimulus(8'hBE, 1'b1);
      applyStimulus(8'hAD, 1'b1);
      t8 = cycle;
      applyStimulus(8'hDE, 1'b1);
      tEnd = cycle;
      checkOutput("s1_busy_before_timeout", 32'(pg_busy), 32'd1);
      waitDone("s1_done_pulses", 2000);
      checkOutput("s1_write_count", 32'(wrAddr.size()), 32'd2);
      checkOutput("s1_addr0", wrAddrAt(0), 32'd0);
      checkOutput("s1_data0", wrDataAt(0), 32'h1234_5678);
      checkOutput("s1_addr1", wrAddrAt(1), 32'd1);
      checkOutput("s1_data1", wrDataAt(1), 32'hDEAD_BEEF);
      // Stop-bit centre sits 9.5 bits after the start edge, plus a couple of
      // synchronizer cycles, plus the single write-latency cycle.
      lat = wrCycleAt(0) - t4;
      checkOutput("s1_latency0_in_window", 32'(lat >= 154 && lat <= 158), 32'd1);
      lat = wrCycleAt(1) - t8;
      checkOutput("s1_latency1_in_window", 32'(lat >= 154 && lat <= 158), 32'd1);
      checkOutput("s1_we_single_cycle", 32'(weLong), 32'd0);
      lat = doneCycle - tEnd;
      checkOutput("s1_timeout_in_window", 32'(lat >= 300 && lat <= 340), 32'd1);
      checkOutput("s1_frame_err", 32'(frame_err), 32'd0);
      checkOutput("s1_pg_busy_after", 32'(pg_busy), 32'd0);
      checkOutput("s1_held_addr", 32'(imem_addr), 32'd1);
      checkOutput("s1_held_wdata", imem_wdata, 32'hDEAD_BEEF);

      // Six bytes: one full word then a zero-padded partial word at timeout.
      clearLog();
      startSession();
      for (int i = 1; i <= 6; i++) applyStimulus(8'(i), 1'b1);
      waitDone("s2_done_pulses", 2000);
      checkOutput("s2_write_count", 32'(wrAddr.size()), 32'd2);
      checkOutput("s2_addr0", wrAddrAt(0), 32'd0);
      checkOutput("s2_data0", wrDataAt(0), 32'h0403_0201);
      checkOutput("s2_addr1", wrAddrAt(1), 32'd1);
      checkOutput("s2_data1", wrDataAt(1), 32'h0000_0605);

      // Bad stop bit: byte dropped, framing error sticky, packing unaffected.
      clearLog();
      startSession();
      applyStimulus(8'h55, 1'b0);
      repeat (32) @(negedge clk);
      checkOutput("s3_frame_err_set", 32'(frame_err), 32'd1);
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      applyStimulus(8'h33, 1'b1);
      applyStimulus(8'h44, 1'b1);
      waitDone("s3_done_pulses", 2000);
      checkOutput("s3_write_count", 32'(wrAddr.size()), 32'd1);
      checkOutput("s3_addr0", wrAddrAt(0), 32'd0);
      checkOutput("s3_data0", wrDataAt(0), 32'h4433_2211);
      checkOutput("s3_frame_err_sticky", 32'(frame_err), 32'd1);

      // One-cycle glitch: rejected as a false start; frame_err cleared.
      clearLog();
      startSession();
      checkOutput("s4_frame_err_cleared", 32'(frame_err), 32'd0);
      repeat (20) @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      waitDone("s4_done_pulses", 2000);
      checkOutput("s4_write_count", 32'(wrAddr.size()), 32'd0);
      checkOutput("s4_frame_err", 32'(frame_err), 32'd0);

      // 17 words into a 16-word memory: last word dropped, ovf set, no wrap.
      clearLog();
      startSession();
      for (int w = 0; w < 17; w++) begin
         for (int k = 0; k < 4; k++) applyStimulus(8'(4 * w + k), 1'b1);
      end
      waitDone("s5_done_pulses", 2000);
      checkOutput("s5_write_count", 32'(wrAddr.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         expWord = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
         checkOutput($sformatf("s5_addr%0d", i), wrAddrAt(i), 32'(i));
         checkOutput($sformatf("s5_data%0d", i), wrDataAt(i), expWord);
      end
      checkOutput("s5_ovf", 32'(ovf), 32'd1);

      // Reset mid-byte in a new session: immediate idle, nothing written.
      clearLog();
      startSession();
      checkOutput("s6_ovf_cleared", 32'(ovf), 32'd0);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         repeat (CPB) @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      checkOutput("s6_busy_in_reset", 32'(pg_busy), 32'd0);
      checkOutput("s6_we_in_reset", 32'(imem_we), 32'd0);
      checkOutput("s6_addr_in_reset", 32'(imem_addr), 32'd0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      busySeen = 0;
      repeat (500) @(negedge clk);
      checkOutput("s6_write_count", 32'(wrAddr.size()), 32'd0);
      checkOutput("s6_busy_after", 32'(busySeen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART program loader upstream of the CPU core.
- On a start_pg rising edge it enters programming mode and holds the CPU in reset via pg_busy.
- It receives 8N1 bytes on rx, packs them little-endian into 32-bit words, and writes the words into instruction memory from address 0.
- The session ends after an idle timeout on rx; the CPU is then released.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
- IDLE_BITS, 1000, number of bit periods with no start bit that ends the session.
- ADDR_WIDTH, 14, imem word-address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_pg  in  1  programming request, raw board input, async.
- rx  in  1  UART serial input, raw async, idle high.
- pg_busy  out  1  high throughout a session; CPU held in reset while high.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  write data.
- pg_done  out  1  one-cycle pulse when the session ends.
- frame_err  out  1  sticky; set on a bad stop bit; cleared at session start.
- ovf  out  1  sticky; set when a word is dropped for address overflow; cleared at session start.

Behaviour:
- Reset: all outputs 0. State IDLE. Word buffer, byte index and address all 0.
- Synchronizers: 2-FF synchronizers on start_pg and rx.
  - start_pg synchronizer and its edge register reset to 1, so an input held high through reset does not trigger a session.
  - rx synchronizer resets to 1.
- IDLE: on a synchronized start_pg 0→1 edge, go to WAIT_START. Next cycle: pg_busy=1, frame_err=0, ovf=0, addr=0, byte index=0.
- start_pg edges during a session are ignored.
- WAIT_START:
  - Idle counter increments each cycle.
  - rx==0 → START; idle counter cleared.
  - Counter reaches IDLE_BITS*CLKS_PER_BIT → FLUSH.
- START: wait CLKS_PER_BIT/2 cycles, then sample rx.
  - rx==1 → false start, back to WAIT_START with idle counter cleared.
  - rx==0 → DATA.
- DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first, shifted into the byte register. Then → STOP.
- STOP: sample rx after CLKS_PER_BIT cycles.
  - rx==0: set frame_err, discard the byte (byte index unchanged), → WAIT_START.
  - rx==1: store the byte into the word buffer lane [8*idx+7 : 8*idx], idx++.
    - If idx was 3 → COMMIT.
    - Otherwise → WAIT_START.
- COMMIT (one cycle):
  - If addr is not yet exhausted: imem_we=1, imem_wdata=buffer, imem_addr=addr; then addr++.
  - If all 2^ADDR_WIDTH words are already written: no write; set ovf.
  - Clear buffer and idx. → WAIT_START.
  - Latency: imem_we is asserted exactly 1 cycle after the stop-bit sample of the 4th byte.
- Address exhaustion:
  - addr saturates logically: after the write to 2^ADDR_WIDTH-1, an exhausted flag is set.
  - No wrap to 0 ever occurs.
- FLUSH (one cycle):
  - If idx>0: write the partial word with unfilled upper bytes zero, same rules as COMMIT.
  - → DONE.
- DONE (one cycle): pg_done=1, pg_busy=0 from the next cycle. → IDLE.
- Zero-byte session: times out, no writes, pg_done pulses.
- rx activity outside a session is ignored.
- rst_n low mid-session: immediate return to IDLE with all outputs 0. Any word in flight is lost; no partial write occurs.
- imem_addr and imem_wdata are held at their last values when imem_we=0.

Decomposition:
- Package prog_loader_pkg:
  - state enum: IDLE, WAIT_START, START, DATA, STOP, COMMIT, FLUSH, DONE.
  - Constants: UART_DATA_BITS=8, WORD_BYTES=4.
- Sub-module uart_rx_byte: synchronizer, mid-bit sampling, byte_valid/byte_data/frame_err outputs, and a busy signal for the idle counter.
  - Loader FSM sits above it: session control, packing, timeout, write port.

Test Plan (CLKS_PER_BIT=16, IDLE_BITS=20, ADDR_WIDTH=4):
- Reset with start_pg held 1, then release → pg_busy stays 0 for 2000 cycles; no writes.
- Pulse start_pg; send bytes 0x78 0x56 0x34 0x12 0xEF 0xBE 0xAD 0xDE → writes (addr 0, 0x12345678) and (addr 1, 0xDEADBEEF). Each imem_we is 1 cycle, 1 cycle after the 4th stop sample. pg_done follows 320 idle cycles later; frame_err=0.
- Session with 6 bytes 01 02 03 04 05 06 → write (0, 0x04030201), then after timeout (1, 0x00000605), then pg_done.
- Send 0x55 with stop bit 0, then 0x11 0x22 0x33 0x44 → frame_err=1; single write (0, 0x44332211).
- 1-cycle 0 glitch on rx (shorter than half a bit) → no byte received; the timeout still ends the session with no writes.
- 17 words sent → addresses 0..15 written; 17th word not written; ovf=1. Assert rst_n low mid-byte in a second session → pg_busy=0 immediately, no imem_we.
